// File: rtl/fmips_unified_mem_if.sv
// Bus bundle for the unified memory: an instruction-fetch master and a
// data load/store master sharing one slave.
interface fmips_unified_mem_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic                  i_ce;
  logic [ADDR_W-1:0]     i_addr;
  logic [DATA_W-1:0]     i_rdata;
  logic                  i_valid;
  logic                  i_stall;

  logic                  d_ce;
  logic                  d_we;
  logic [ADDR_W-1:0]     d_addr;
  logic [DATA_W/8-1:0]   d_sel;
  logic [DATA_W-1:0]     d_wdata;
  logic [DATA_W-1:0]     d_rdata;
  logic                  d_valid;
  logic                  d_err;
  logic                  d_stall;

  modport master (
    output i_ce, i_addr,
    input  i_rdata, i_valid, i_stall,
    output d_ce, d_we, d_addr, d_sel, d_wdata,
    input  d_rdata, d_valid, d_err, d_stall
  );

  modport slave (
    input  i_ce, i_addr,
    output i_rdata, i_valid, i_stall,
    input  d_ce, d_we, d_addr, d_sel, d_wdata,
    output d_rdata, d_valid, d_err, d_stall
  );
endinterface

// File: rtl/fmips_unified_mem.sv
// Shared instruction/data word array behind a two-master arbiter with
// byte-lane writes, range checking and starvation-bounded priority.
module fmips_unified_mem #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32,
  parameter int DEPTH_LOG2 = 10,
  parameter int DATA_FIRST = 1,
  parameter int STARVE_MAX = 3
) (
  input  logic               clk,
  input  logic               rst,
  fmips_unified_mem_if.slave bus
);
  localparam int LANES = DATA_W / 8;
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CNT_W = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
  localparam logic [CNT_W-1:0] STARVE_TC = CNT_W'(STARVE_MAX);

  logic [DATA_W-1:0]     mem [DEPTH];

  logic [CNT_W-1:0]      starve_left;
  logic                  conflict;
  logic                  forced;
  logic                  grant_i;
  logic                  grant_d;

  logic [ADDR_W-1:0]     acc_addr;
  logic [DEPTH_LOG2-1:0] acc_idx;
  logic                  acc_oor;
  logic                  wr_commit;
  logic [DATA_W-1:0]     rd_word;

  logic [DATA_W-1:0]     i_rdata_q;
  logic                  i_valid_q;
  logic [DATA_W-1:0]     d_rdata_q;
  logic                  d_valid_q;
  logic                  d_err_q;

  // starve_left counts down the conflicts the non-default port may still lose;
  // reaching zero hands it the next conflict.
  always_comb begin
    conflict = bus.i_ce & bus.d_ce;
    forced   = conflict & (starve_left == '0);
    grant_i  = bus.i_ce;
    grant_d  = bus.d_ce;
    if (conflict) begin
      grant_d = (DATA_FIRST != 0) ? ~forced : forced;
      grant_i = ~grant_d;
    end
  end

  assign bus.i_stall = bus.i_ce & ~grant_i;
  assign bus.d_stall = bus.d_ce & ~grant_d;

  assign acc_addr  = grant_d ? bus.d_addr : bus.i_addr;
  assign acc_idx   = acc_addr[DEPTH_LOG2+1:2];
  assign acc_oor   = |(acc_addr >> (DEPTH_LOG2 + 2));
  assign rd_word   = mem[acc_idx];
  // Holding rst low blocks the commit, so an access granted as reset falls never lands.
  assign wr_commit = grant_d & bus.d_we & ~acc_oor & rst;

  always_ff @(posedge clk) begin
    if (wr_commit) begin
      for (int k = 0; k < LANES; k++) begin
        if (bus.d_sel[k]) begin
          mem[acc_idx][8*k +: 8] <= bus.d_wdata[8*k +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_left <= STARVE_TC;
      i_rdata_q   <= '0;
      i_valid_q   <= 1'b0;
      d_rdata_q   <= '0;
      d_valid_q   <= 1'b0;
      d_err_q     <= 1'b0;
    end else begin
      if (conflict && !forced) begin
        starve_left <= starve_left - 1'b1;
      end else begin
        starve_left <= STARVE_TC;
      end

      i_valid_q <= grant_i;
      d_valid_q <= grant_d;
      d_err_q   <= grant_d & acc_oor;

      if (grant_i) begin
        i_rdata_q <= acc_oor ? '0 : rd_word;
      end
      if (grant_d && !bus.d_we) begin
        d_rdata_q <= acc_oor ? '0 : rd_word;
      end
    end
  end

  assign bus.i_rdata = i_rdata_q;
  assign bus.i_valid = i_valid_q;
  assign bus.d_rdata = d_rdata_q;
  assign bus.d_valid = d_valid_q;
  assign bus.d_err   = d_err_q;

endmodule
